sprite_anim_seq: RTL and testbench

SPRITE_ANIM_SEQ -- requirements
Module: sprite_anim_seq

---
 rtl/sprite_anim_pkg.sv | 40 ++++
 rtl/sprite_addr_pipe.sv | 113 +++++++++++
 rtl/sprite_anim_seq.sv | 143 ++++++++++++++
 tb/tb_sprite_anim_seq.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_anim_pkg.sv
// Shared types and constants for the sprite animation sequencer: pose
// geometry table, sprite-sheet layout and the sequencer state encoding.
package sprite_anim_pkg;

  localparam int DIM_W      = 8;   // sprite width/height in sheet pixels
  localparam int BASE_W     = 24;  // base address field, truncated at the ROM port
  localparam int CNT_W      = 4;   // frame count field (1..MAX_FRAMES)
  localparam int POSE_IDX_W = 3;   // index width of the pose table
  localparam int H_MAX      = 112; // tallest pose; shorter poses are bottom-aligned

  typedef struct packed {
    logic [DIM_W-1:0]  w;
    logic [DIM_W-1:0]  h;
    logic [BASE_W-1:0] base;
    logic [CNT_W-1:0]  n;
    logic              oneshot;
  } pose_t;

  typedef enum logic {
    ST_LOOP    = 1'b0,
    ST_ONESHOT = 1'b1
  } anim_state_e;

  // Poses are packed back to back in the sprite ROM, frames of a pose
  // contiguous, each frame stored row-major at w*h words.
  localparam pose_t POSE_STAND   = '{w: 8'd80,  h: 8'd112, base: 24'd0,      n: 4'd6, oneshot: 1'b0};
  localparam pose_t POSE_FORWARD = '{w: 8'd96,  h: 8'd112, base: 24'd53760,  n: 4'd4, oneshot: 1'b0};
  localparam pose_t POSE_BACK    = '{w: 8'd80,  h: 8'd112, base: 24'd96768,  n: 4'd4, oneshot: 1'b0};
  localparam pose_t POSE_PUNCH   = '{w: 8'd128, h: 8'd96,  base: 24'd132608, n: 4'd4, oneshot: 1'b1};
  localparam pose_t POSE_SQUAT   = '{w: 8'd80,  h: 8'd64,  base: 24'd181760, n: 4'd1, oneshot: 1'b0};
  localparam pose_t POSE_KICK    = '{w: 8'd112, h: 8'd112, base: 24'd186880, n: 4'd5, oneshot: 1'b1};

  // Full power-of-two table so any index is in range; unused slots fall
  // back to the standing pose.
  localparam pose_t POSE_TABLE [2**POSE_IDX_W] = '{
    POSE_STAND, POSE_FORWARD, POSE_BACK, POSE_PUNCH,
    POSE_SQUAT, POSE_KICK,    POSE_STAND, POSE_STAND
  };

endpackage

// File: rtl/sprite_addr_pipe.sv
// Two-stage pixel pipeline: stage 1 places the pose box on screen, tests
// the pixel against it and forms row/column offsets; stage 2 turns those
// into a sprite ROM address.
module sprite_addr_pipe
  import sprite_anim_pkg::*;
#(
  parameter int POSE_W      = 3,
  parameter int FRAME_W     = 3,
  parameter int ADDR_W      = 18,
  parameter int COORD_W     = 13,
  parameter int SCALE_SHIFT = 1
) (
  input  logic               clk_25MHz,
  input  logic               reset,
  input  logic [POSE_W-1:0]  pose_i,
  input  logic [FRAME_W-1:0] frame_i,
  input  logic [COORD_W-1:0] origin_x_i,
  input  logic [COORD_W-1:0] origin_y_i,
  input  logic [9:0]         draw_x_i,
  input  logic [9:0]         draw_y_i,
  output logic [ADDR_W-1:0]  addr_o,
  output logic               hit_o
);

  // One spare bit so origin + box size never wraps back onto the screen.
  localparam int CW = COORD_W + 1;

  logic [DIM_W-1:0]  w_s1, h_s1, pad_rows;
  logic [BASE_W-1:0] base_s1;
  logic [CW-1:0]     px, py, box_l, box_t, box_r, box_b, dx, dy;
  logic              hit_s1;
  logic [DIM_W-1:0]  col_s1, row_s1;

  logic              hit_q1;
  logic [DIM_W-1:0]  col_q1, row_q1, w_q1, h_q1;
  logic [BASE_W-1:0] base_q1;
  logic [FRAME_W-1:0] frame_q1;

  logic [31:0]       sum_s2;
  logic [ADDR_W-1:0] addr_d, addr_q;
  logic              hit_q;

  // Stage 1: box placement, inclusive/exclusive bounds test, pixel offsets.
  always_comb begin
    w_s1     = POSE_TABLE[POSE_IDX_W'(pose_i)].w;
    h_s1     = POSE_TABLE[POSE_IDX_W'(pose_i)].h;
    base_s1  = POSE_TABLE[POSE_IDX_W'(pose_i)].base;
    pad_rows = DIM_W'(H_MAX) - h_s1;
    px       = CW'(draw_x_i);
    py       = CW'(draw_y_i);
    box_l    = CW'(origin_x_i);
    box_t    = CW'(origin_y_i) + (CW'(pad_rows) << SCALE_SHIFT);
    box_r    = box_l + (CW'(w_s1) << SCALE_SHIFT);
    box_b    = box_t + (CW'(h_s1) << SCALE_SHIFT);
    hit_s1   = (px >= box_l) && (px < box_r) && (py >= box_t) && (py < box_b);
    dx       = px - box_l;
    dy       = py - box_t;
    col_s1   = DIM_W'(dx >> SCALE_SHIFT);
    row_s1   = DIM_W'(dy >> SCALE_SHIFT);
  end

  // Stage 1 register: pixel result captured together with pose and frame.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value, independent of statement order.
  // NOTE: pipeline data registers are reset too, so the outputs are a
  // clean 0 straight out of reset instead of stale or unknown values.
  always_ff @(posedge clk_25MHz or negedge reset) begin
    if (!reset) begin
      hit_q1   <= 1'b0;
      col_q1   <= '0;
      row_q1   <= '0;
      w_q1     <= '0;
      h_q1     <= '0;
      base_q1  <= '0;
      frame_q1 <= '0;
    end else begin
      hit_q1   <= hit_s1;
      col_q1   <= col_s1;
      row_q1   <= row_s1;
      w_q1     <= w_s1;
      h_q1     <= h_s1;
      base_q1  <= base_s1;
      frame_q1 <= frame_i;
    end
  end

  // Stage 2: frame offset plus row-major pixel offset; forced to 0 on a miss.
  // NOTE: every combinational output gets a value on every path (here a
  // default first), otherwise synthesis infers a latch.
  always_comb begin
    addr_d = '0;
    sum_s2 = 32'(base_q1)
           + 32'(frame_q1) * 32'(w_q1) * 32'(h_q1)
           + 32'(w_q1) * 32'(row_q1)
           + 32'(col_q1);
    if (hit_q1) addr_d = ADDR_W'(sum_s2);
  end

  // Stage 2 register: drives the ROM address and hit flag.
  always_ff @(posedge clk_25MHz or negedge reset) begin
    if (!reset) begin
      addr_q <= '0;
      hit_q  <= 1'b0;
    end else begin
      addr_q <= addr_d;
      hit_q  <= hit_q1;
    end
  end

  assign addr_o = addr_q;
  assign hit_o  = hit_q;

endmodule

// File: rtl/sprite_anim_seq.sv
// Sprite animation sequencer: advances pose frames on vsync ticks, runs
// one-shot poses to completion, and feeds the pixel address pipeline.
module sprite_anim_seq
  import sprite_anim_pkg::*;
#(
  parameter int NUM_POSES   = 6,
  parameter int MAX_FRAMES  = 8,
  parameter int ADDR_W      = 18,
  parameter int COORD_W     = 13,
  parameter int SCALE_SHIFT = 1,
  parameter int HOLD_TICKS  = 7
) (
  input  logic                          clk_25MHz,
  input  logic                          reset,
  input  logic                          vsync,
  input  logic [$clog2(NUM_POSES)-1:0]  pose_sel,
  input  logic [COORD_W-1:0]            origin_x,
  input  logic [COORD_W-1:0]            origin_y,
  input  logic [9:0]                    DrawX,
  input  logic [9:0]                    DrawY,
  output logic [ADDR_W-1:0]             sprite_addr,
  output logic                          sprite_hit,
  output logic [$clog2(NUM_POSES)-1:0]  cur_pose,
  output logic [$clog2(MAX_FRAMES)-1:0] cur_frame,
  output logic                          busy,
  output logic                          done
);

  localparam int POSE_W  = $clog2(NUM_POSES);
  localparam int FRAME_W = $clog2(MAX_FRAMES);
  localparam int FC_W    = FRAME_W + 1;
  localparam int HOLD_W  = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_TICKS - 1);

  logic               vsync_q, tick;
  anim_state_e        state_q, state_d;
  logic [POSE_W-1:0]  pose_q, pose_d;
  logic [FRAME_W-1:0] frame_q, frame_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic               done_q, done_d;
  logic [CNT_W-1:0]   cur_n;
  logic               sel_oneshot, hold_wrap, frame_last;

  // Frame tick: one-cycle pulse on a rising edge of vsync.
  always_ff @(posedge clk_25MHz or negedge reset) begin
    if (!reset) vsync_q <= 1'b0;
    else        vsync_q <= vsync;
  end

  assign tick = vsync & ~vsync_q;

  // Table lookups and end-of-hold / end-of-pose conditions.
  always_comb begin
    cur_n       = POSE_TABLE[POSE_IDX_W'(pose_q)].n;
    sel_oneshot = POSE_TABLE[POSE_IDX_W'(pose_sel)].oneshot;
    hold_wrap   = (hold_q == HOLD_LAST);
    frame_last  = (FC_W'(frame_q) + FC_W'(1)) == FC_W'(cur_n);
  end

  // Next-state: pose change beats hold counting; one-shots ignore pose_sel
  // until their last frame has been held, then pick it up on completion.
  always_comb begin
    state_d = state_q;
    pose_d  = pose_q;
    frame_d = frame_q;
    hold_d  = hold_q;
    done_d  = 1'b0;
    if (tick) begin
      case (state_q)
        ST_LOOP: begin
          if (pose_sel != pose_q) begin
            pose_d  = pose_sel;
            frame_d = '0;
            hold_d  = '0;
            if (sel_oneshot) state_d = ST_ONESHOT;
          end else if (hold_wrap) begin
            hold_d  = '0;
            frame_d = frame_last ? '0 : frame_q + FRAME_W'(1);
          end else begin
            hold_d  = hold_q + HOLD_W'(1);
          end
        end
        ST_ONESHOT: begin
          if (hold_wrap && frame_last) begin
            done_d  = 1'b1;
            state_d = ST_LOOP;
            pose_d  = pose_sel;
            frame_d = '0;
            hold_d  = '0;
          end else if (hold_wrap) begin
            hold_d  = '0;
            frame_d = frame_q + FRAME_W'(1);
          end else begin
            hold_d  = hold_q + HOLD_W'(1);
          end
        end
        default: state_d = ST_LOOP;
      endcase
    end
  end

  // Sequencer state register; reset aborts any one-shot without a done pulse.
  always_ff @(posedge clk_25MHz or negedge reset) begin
    if (!reset) begin
      state_q <= ST_LOOP;
      pose_q  <= '0;
      frame_q <= '0;
      hold_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pose_q  <= pose_d;
      frame_q <= frame_d;
      hold_q  <= hold_d;
      done_q  <= done_d;
    end
  end

  assign cur_pose  = pose_q;
  assign cur_frame = frame_q;
  assign busy      = (state_q == ST_ONESHOT);
  assign done      = done_q;

  sprite_addr_pipe #(
    .POSE_W      (POSE_W),
    .FRAME_W     (FRAME_W),
    .ADDR_W      (ADDR_W),
    .COORD_W     (COORD_W),
    .SCALE_SHIFT (SCALE_SHIFT)
  ) u_addr_pipe (
    .clk_25MHz  (clk_25MHz),
    .reset      (reset),
    .pose_i     (pose_q),
    .frame_i    (frame_q),
    .origin_x_i (origin_x),
    .origin_y_i (origin_y),
    .draw_x_i   (DrawX),
    .draw_y_i   (DrawY),
    .addr_o     (sprite_addr),
    .hit_o      (sprite_hit)
  );

endmodule

// File: tb/tb_sprite_anim_seq.sv
// Self-checking bench for sprite_anim_seq: directed scenarios followed by
// randomized pose requests and pixel probes against a behavioural model.
`timescale 1ns/1ps
module tb_sprite_anim_seq;

  localparam int NUM_POSES   = 6;
  localparam int MAX_FRAMES  = 8;
  localparam int ADDR_W      = 18;
  localparam int COORD_W     = 13;
  localparam int SCALE_SHIFT = 1;
  localparam int HOLD_TICKS  = 7;
  localparam int SCALE       = 1 << SCALE_SHIFT;
  localparam int HMAX        = 112;

  logic               clk_25MHz = 1'b0;
  logic               reset     = 1'b0;
  logic               vsync     = 1'b0;
  logic [2:0]         pose_sel  = '0;
  logic [COORD_W-1:0] origin_x  = '0;
  logic [COORD_W-1:0] origin_y  = '0;
  logic [9:0]         DrawX     = '0;
  logic [9:0]         DrawY     = '0;
  logic [ADDR_W-1:0]  sprite_addr;
  logic               sprite_hit;
  logic [2:0]         cur_pose;
  logic [2:0]         cur_frame;
  logic               busy;
  logic               done;

  int n_tests  = 0;
  int n_fail   = 0;
  int done_cnt = 0;

  // Pose sheet: width, height, frame count, one-shot flag.
  int pw [6] = '{80, 96, 80, 128, 80, 112};
  int ph [6] = '{112, 112, 112, 96, 64, 112};
  int pn [6] = '{6, 4, 4, 4, 1, 5};
  int pos[6] = '{0, 0, 0, 1, 0, 1};
  int pbase[6];

  // Model: active pose, ticks since it started, one-shot flag, done count.
  int m_pose, m_age, m_busy, m_done;

  sprite_anim_seq #(
    .NUM_POSES   (NUM_POSES),
    .MAX_FRAMES  (MAX_FRAMES),
    .ADDR_W      (ADDR_W),
    .COORD_W     (COORD_W),
    .SCALE_SHIFT (SCALE_SHIFT),
    .HOLD_TICKS  (HOLD_TICKS)
  ) dut (
    .clk_25MHz   (clk_25MHz),
    .reset       (reset),
    .vsync       (vsync),
    .pose_sel    (pose_sel),
    .origin_x    (origin_x),
    .origin_y    (origin_y),
    .DrawX       (DrawX),
    .DrawY       (DrawY),
    .sprite_addr (sprite_addr),
    .sprite_hit  (sprite_hit),
    .cur_pose    (cur_pose),
    .cur_frame   (cur_frame),
    .busy        (busy),
    .done        (done)
  );

  always #20 clk_25MHz = ~clk_25MHz;

  always @(negedge clk_25MHz) if (done === 1'b1) done_cnt++;

  initial begin
    #(40 * 60000);
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int m_frame();
    return (m_age / HOLD_TICKS) % pn[m_pose];
  endfunction

  task automatic model_tick(input int sel);
    if (m_busy == 0 && sel != m_pose) begin
      m_pose = sel;
      m_age  = 0;
      m_busy = pos[sel];
    end else begin
      m_age++;
      if (m_busy != 0 && m_age == HOLD_TICKS * pn[m_pose]) begin
        m_done++;
        m_busy = 0;
        m_pose = sel;
        m_age  = 0;
      end
    end
  endtask

  task automatic model_reset();
    m_pose = 0;
    m_age  = 0;
    m_busy = 0;
  endtask

  function automatic void model_pix(input int p, input int f, input int ox, input int oy,
                                    input int x, input int y, output int hit, output int addr);
    int top;
    top  = oy + (HMAX - ph[p]) * SCALE;
    hit  = (x >= ox && x < ox + pw[p] * SCALE && y >= top && y < top + ph[p] * SCALE) ? 1 : 0;
    addr = 0;
    if (hit != 0)
      addr = (pbase[p] + f * pw[p] * ph[p] + pw[p] * ((y - top) / SCALE) + (x - ox) / SCALE)
             % (1 << ADDR_W);
  endfunction

  // One frame tick: vsync high for two clocks, low for two.
  task automatic do_tick(input int sel);
    @(negedge clk_25MHz);
    pose_sel = 3'(sel);
    vsync    = 1'b1;
    model_tick(sel);
    @(negedge clk_25MHz);
    @(negedge clk_25MHz);
    vsync = 1'b0;
    @(negedge clk_25MHz);
  endtask

  task automatic check_state(input string tag);
    check($sformatf("%s.pose", tag),  32'(cur_pose),  m_pose);
    check($sformatf("%s.frame", tag), 32'(cur_frame), m_frame());
    check($sformatf("%s.busy", tag),  32'(busy),      m_busy);
    check($sformatf("%s.done", tag),  done_cnt,       m_done);
  endtask

  // Drive a pixel, wait the two-clock pipeline, compare hit and address.
  task automatic pix_check(input string tag, input int ox, input int oy, input int x, input int y);
    int eh, ea;
    @(negedge clk_25MHz);
    origin_x = COORD_W'(ox);
    origin_y = COORD_W'(oy);
    DrawX    = 10'(x);
    DrawY    = 10'(y);
    @(negedge clk_25MHz);
    @(negedge clk_25MHz);
    model_pix(m_pose, m_frame(), ox, oy, x, y, eh, ea);
    check($sformatf("%s.hit", tag),  32'(sprite_hit),  eh);
    check($sformatf("%s.addr", tag), 32'(sprite_addr), ea);
  endtask

  initial begin
    int acc, d0, sel, ox, oy, x, y;
    int edge_px[5][2];

    acc = 0;
    for (int i = 0; i < 6; i++) begin
      pbase[i] = acc;
      acc += pw[i] * ph[i] * pn[i];
    end
    model_reset();
    m_done = 0;

    // Reset: inputs point inside a box, outputs must still read zero.
    origin_x = 13'd100; origin_y = 13'd200; DrawX = 10'd110; DrawY = 10'd210;
    repeat (3) @(negedge clk_25MHz);
    check("rst.addr",  32'(sprite_addr), 0);
    check("rst.hit",   32'(sprite_hit),  0);
    check("rst.pose",  32'(cur_pose),    0);
    check("rst.frame", 32'(cur_frame),   0);
    check("rst.busy",  32'(busy),        0);
    check("rst.done",  32'(done),        0);
    reset = 1'b1;

    // Standing loop: six frames, seven ticks each, wrapping at tick 42.
    for (int k = 1; k <= 42; k++) begin
      do_tick(0);
      check_state($sformatf("stand%0d", k));
      check($sformatf("stand%0d.formula", k), 32'(cur_frame), (k / 7) % 6);
    end

    // Address of a pixel in standing frame 2.
    for (int g = 0; g < 60 && m_frame() != 2; g++) do_tick(0);
    pix_check("addr", 100, 200, 110, 210);
    check("addr.const_hit",  32'(sprite_hit),  1);
    check("addr.const_addr", 32'(sprite_addr), 18325);

    // Box edges: inclusive left/top, exclusive right/bottom.
    edge_px = '{'{99, 300}, '{100, 300}, '{259, 300}, '{260, 300}, '{150, 424}};
    for (int i = 0; i < 5; i++)
      pix_check($sformatf("edge%0d", i), 100, 200, edge_px[i][0], edge_px[i][1]);
    pix_check("edge_top_in", 100, 200, 150, 200);
    pix_check("edge_top_out", 100, 200, 150, 199);
    pix_check("edge_bot_in", 100, 200, 150, 423);

    // Pose change on the tick where hold is at its last count.
    for (int g = 0; g < 10 && (m_age % HOLD_TICKS) != HOLD_TICKS - 1; g++) do_tick(0);
    do_tick(1);
    check("chg.pose",  32'(cur_pose),  1);
    check("chg.frame", 32'(cur_frame), 0);
    for (int k = 1; k <= 7; k++) begin
      do_tick(1);
      check_state($sformatf("chg%0d", k));
    end
    check("chg.hold_restart", 32'(cur_frame), 1);

    // Punch one-shot: requested for one tick, then stand requested.
    d0 = done_cnt;
    do_tick(3);
    check_state("punch0");
    check("punch.busy_on", 32'(busy), 1);
    // Bottom alignment of the shorter punch box.
    pix_check("balign_above", 100, 200, 100, 231);
    check("balign.above_hit", 32'(sprite_hit), 0);
    pix_check("balign_row0", 100, 200, 100, 232);
    check("balign.row0_hit",  32'(sprite_hit),  1);
    check("balign.row0_addr", 32'(sprite_addr), 132608);
    for (int k = 1; k <= 28; k++) begin
      do_tick(0);
      check_state($sformatf("punch%0d", k));
    end
    check("punch.done_once", done_cnt - d0, 1);
    check("punch.busy_off",  32'(busy),     0);
    check("punch.pose_back", 32'(cur_pose), 0);

    // Randomized pose requests with pixel probes.
    sel = 0;
    for (int it = 0; it < 220; it++) begin
      if ($urandom_range(0, 9) < 3) sel = int'($urandom_range(0, 5));
      do_tick(sel);
      check_state($sformatf("rnd%0d", it));
      if (it % 3 == 0) begin
        ox = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1024, 8100)) : int'($urandom_range(0, 800));
        oy = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1024, 8100)) : int'($urandom_range(0, 800));
        x  = ox + int'($urandom_range(0, pw[m_pose] * SCALE + 16)) - 8;
        y  = oy + (HMAX - ph[m_pose]) * SCALE + int'($urandom_range(0, ph[m_pose] * SCALE + 16)) - 8;
        if (x < 0) x = 0;
        if (x > 1023) x = 1023;
        if (y < 0) y = 0;
        if (y > 1023) y = 1023;
        pix_check($sformatf("rndpix%0d", it), ox, oy, x, y);
      end
    end

    // Reset in the middle of a one-shot aborts it without a done pulse.
    for (int g = 0; g < 80 && m_busy != 0; g++) do_tick(m_pose);
    sel = (m_pose == 5) ? 3 : 5;
    do_tick(sel);
    for (int k = 0; k < 10; k++) do_tick(0);
    check("abort.busy_before", 32'(busy), 1);
    d0 = done_cnt;
    @(negedge clk_25MHz);
    reset = 1'b0;
    model_reset();
    repeat (3) @(negedge clk_25MHz);
    check("abort.busy",  32'(busy),      0);
    check("abort.pose",  32'(cur_pose),  0);
    check("abort.frame", 32'(cur_frame), 0);
    check("abort.hit",   32'(sprite_hit), 0);
    reset = 1'b1;
    repeat (4) @(negedge clk_25MHz);
    check("abort.no_done", done_cnt - d0, 0);
    do_tick(0);
    check_state("abort.after");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
